fp_mul_norm_round: RTL

- Downstream neighbour of the FP_Mul mantissa multiplier.
- Consumes the raw 48-bit mantissa product plus the sign, exponent sum and special-case flags from the operand-unpack logic.
- Normalizes, rounds and packs the result into an IEEE-754 single-precision word.
- Two-stage pipeline with valid/ready handshakes on both sides and full throughput.

---
 rtl/fp_mul_pkg.sv | 36 +++
 rtl/fp_mul_round.sv | 78 +++++++
 rtl/fp_mul_norm_round.sv | 106 ++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared constants, rounding modes and stage-1 payload for the FP multiply back end
package fp_mul_pkg;

    localparam int FP_MANT_W  = 23;
    localparam int FP_EXP_W   = 8;
    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    // Internal exponent keeps two guard bits above the biased field so
    // overflow and underflow remain visible as plain signed compares.
    localparam int EXP_IW = FP_EXP_W + 3;
    typedef logic signed [EXP_IW-1:0] exp_int_t;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RZ  = 2'b01,
        RM_RU  = 2'b10,
        RM_RD  = 2'b11
    } rmode_t;

    typedef struct packed {
        logic                 sign;
        exp_int_t             exp;
        logic [FP_MANT_W-1:0] mant;
        logic                 g;
        logic                 s;
        logic                 zero;
        logic                 inf;
        logic                 nan;
`ifdef FP_MUL_RMODE_EN
        rmode_t               rmode;
`endif
    } s1_payload_t;

endpackage

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - combinational round, renormalize and pack (directed modes when FP_MUL_RMODE_EN)
module fp_mul_round
    import fp_mul_pkg::*;
(
    input  s1_payload_t                    pl,
    output logic [FP_MANT_W+FP_EXP_W:0]    result,
    output logic                           overflow,
    output logic                           underflow,
    output logic                           inexact
);

    logic                   up;
    logic                   rnd_any;
    logic                   sat_max;
    logic [FP_MANT_W+1:0]   sum;
    logic [FP_MANT_W-1:0]   mant_r;
    exp_int_t               exp_r;

    always_comb begin
        rnd_any = pl.g | pl.s;
        up      = pl.g & (pl.s | pl.mant[0]);
        sat_max = 1'b0;
`ifdef FP_MUL_RMODE_EN
        // sat_max marks modes that round toward zero for this sign, which clamp to max-finite
        case (pl.rmode)
            RM_RZ: begin
                up      = 1'b0;
                sat_max = 1'b1;
            end
            RM_RU: begin
                up      = ~pl.sign & rnd_any;
                sat_max = pl.sign;
            end
            RM_RD: begin
                up      = pl.sign & rnd_any;
                sat_max = ~pl.sign;
            end
            default: ;
        endcase
`endif
        sum = {2'b01, pl.mant} + {{(FP_MANT_W+1){1'b0}}, up};
        if (sum[FP_MANT_W+1]) begin
            mant_r = sum[FP_MANT_W:1];
            exp_r  = pl.exp + exp_int_t'(1);
        end else begin
            mant_r = sum[FP_MANT_W-1:0];
            exp_r  = pl.exp;
        end

        result    = {pl.sign, exp_r[FP_EXP_W-1:0], mant_r};
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = rnd_any;

        if (pl.nan) begin
            result  = FP_QNAN;
            inexact = 1'b0;
        end else if (pl.inf) begin
            result  = {pl.sign, {FP_EXP_W{1'b1}}, {FP_MANT_W{1'b0}}};
            inexact = 1'b0;
        end else if (pl.zero) begin
            result  = {pl.sign, {(FP_EXP_W+FP_MANT_W){1'b0}}};
            inexact = 1'b0;
        end else if (exp_r >= exp_int_t'(FP_EXP_MAX)) begin
            overflow = 1'b1;
            inexact  = 1'b1;
            if (sat_max)
                result = {pl.sign, {(FP_EXP_W-1){1'b1}}, 1'b0, {FP_MANT_W{1'b1}}};
            else
                result = {pl.sign, {FP_EXP_W{1'b1}}, {FP_MANT_W{1'b0}}};
        end else if (exp_r <= exp_int_t'(0)) begin
            result    = {pl.sign, {(FP_EXP_W+FP_MANT_W){1'b0}}};
            underflow = 1'b1;
            inexact   = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// rtl/fp_mul_norm_round.sv - two-stage normalize/round/pack pipeline; FP_MUL_RMODE_EN adds in_rmode
module fp_mul_norm_round
    import fp_mul_pkg::*;
#(
    parameter int MANT_W = FP_MANT_W,
    parameter int EXP_W  = FP_EXP_W
) (
    input  logic                        in_clk,
    input  logic                        in_rst_n,
    input  logic                        in_valid,
    output logic                        out_ready,
    input  logic                        in_sign,
    input  logic signed [EXP_W+1:0]     in_exp_sum,
    input  logic [2*(MANT_W+1)-1:0]     in_product,
    input  logic                        in_zero,
    input  logic                        in_inf,
    input  logic                        in_nan,
`ifdef FP_MUL_RMODE_EN
    input  logic [1:0]                  in_rmode,
`endif
    output logic                        out_valid,
    input  logic                        in_ready,
    output logic [MANT_W+EXP_W:0]       out_result,
    output logic                        out_overflow,
    output logic                        out_underflow,
    output logic                        out_inexact
);

    localparam int PW = 2 * (MANT_W + 1);

    logic           s1_valid;
    s1_payload_t    s1_q;
    s1_payload_t    norm;
    logic           s1_adv;
    logic           s2_adv;
    exp_int_t       exp_in;

    logic [MANT_W+EXP_W:0]  rnd_result;
    logic                   rnd_ovf;
    logic                   rnd_unf;
    logic                   rnd_inx;

    assign s2_adv    = !out_valid || in_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign out_ready = s1_adv && in_rst_n;
    assign exp_in    = exp_int_t'(in_exp_sum);

    // Product of two 1.x mantissas lies in [1,4): the MSB picks the binary point.
    always_comb begin
        norm      = '0;
        norm.sign = in_sign;
        norm.zero = in_zero;
        norm.inf  = in_inf;
        norm.nan  = in_nan;
`ifdef FP_MUL_RMODE_EN
        norm.rmode = rmode_t'(in_rmode);
`endif
        if (in_product[PW-1]) begin
            norm.mant = in_product[PW-2 -: MANT_W];
            norm.g    = in_product[PW-2-MANT_W];
            norm.s    = |in_product[PW-3-MANT_W:0];
            norm.exp  = exp_in + exp_int_t'(1);
        end else begin
            norm.mant = in_product[PW-3 -: MANT_W];
            norm.g    = in_product[PW-3-MANT_W];
            norm.s    = |in_product[PW-4-MANT_W:0];
            norm.exp  = exp_in;
        end
    end

    fp_mul_round u_round (
        .pl        (s1_q),
        .result    (rnd_result),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf),
        .inexact   (rnd_inx)
    );

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            s1_valid      <= 1'b0;
            s1_q          <= '0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_result    <= rnd_result;
                    out_overflow  <= rnd_ovf;
                    out_underflow <= rnd_unf;
                    out_inexact   <= rnd_inx;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid)
                    s1_q <= norm;
            end
        end
    end

endmodule
